// File: rtl/actbuf_port_arbiter.sv
// actbuf_port_arbiter
// Shares the single-port activation buffer SRAM between the external bus port,
// the internal window-read port and the ofmap writeback port. Writebacks are
// queued in a small FIFO so output pulses are never lost while window fetches
// hold the SRAM. At most one SRAM access is granted per cycle.

module actbuf_port_arbiter #(
    parameter int addrWidth   = 12,
    parameter int dataWidth   = 128,
    parameter int wbFifoDepth = 4,   // power of two, >= 2
    parameter int starveLimit = 8    // >= 1
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           clear,

    // external bus port
    input  logic                           ext_req_valid,
    input  logic                           ext_req_wen,
    input  logic [addrWidth-1:0]           ext_req_addr,
    input  logic [dataWidth-1:0]           ext_req_wdata,
    output logic                           ext_req_ready,
    output logic                           ext_rd_valid,
    output logic [dataWidth-1:0]           ext_rd_data,

    // internal window-read port
    input  logic                           ird_req_valid,
    input  logic [addrWidth-1:0]           ird_req_addr,
    output logic                           ird_req_ready,
    output logic                           ird_rd_valid,
    output logic [dataWidth-1:0]           ird_rd_data,

    // ofmap writeback port
    input  logic                           iwr_valid,
    input  logic [addrWidth-1:0]           iwr_addr,
    input  logic [dataWidth-1:0]           iwr_data,
    output logic                           iwr_ready,

    // SRAM macro side
    output logic                           sram_en,
    output logic                           sram_wen,
    output logic [addrWidth-1:0]           sram_addr,
    output logic [dataWidth-1:0]           sram_wdata,
    input  logic [dataWidth-1:0]           sram_rdata,

    // status
    output logic [$clog2(wbFifoDepth):0]   wb_level,
    output logic                           busy
);

    localparam int PtrW = $clog2(wbFifoDepth);
    localparam int LvlW = PtrW + 1;
    localparam int CntW = $clog2(starveLimit + 1);

    // Grant select encoding
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_EXT  = 2'd1;
    localparam logic [1:0] GNT_IRD  = 2'd2;
    localparam logic [1:0] GNT_FIFO = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [addrWidth-1:0] fifo_addr_q [wbFifoDepth];
    logic [dataWidth-1:0] fifo_data_q [wbFifoDepth];

    logic [PtrW-1:0] wptr_q,   wptr_d;
    logic [PtrW-1:0] rptr_q,   rptr_d;
    logic [LvlW-1:0] level_q,  level_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic            rd_pend_q, rd_pend_d;   // a read was granted last cycle
    logic            rd_tag_q,  rd_tag_d;    // 1 = ext owns it, 0 = ird owns it

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [1:0] grant;
    logic       fifo_nonempty;
    logic       fifo_nearly_full;
    logic       ext_starved;
    logic       push;
    logic       pop;

    assign fifo_nonempty    = (level_q != '0);
    assign fifo_nearly_full = (level_q >= LvlW'(wbFifoDepth - 1));
    assign ext_starved      = ext_req_valid && (starve_q == CntW'(starveLimit));

    // Fixed-precedence grant: starved ext, nearly-full FIFO, ird, FIFO, ext.
    // A clear cycle grants nothing.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first so no path leaves it unassigned and infers a latch.
        grant = GNT_NONE;
        if (!clear) begin
            if (ext_starved) begin
                grant = GNT_EXT;
            end else if (fifo_nearly_full && fifo_nonempty) begin
                grant = GNT_FIFO;
            end else if (ird_req_valid) begin
                grant = GNT_IRD;
            end else if (fifo_nonempty) begin
                grant = GNT_FIFO;
            end else if (ext_req_valid) begin
                grant = GNT_EXT;
            end
        end
    end

    assign ext_req_ready = (grant == GNT_EXT);
    assign ird_req_ready = (grant == GNT_IRD);

    // Readiness ignores a same-cycle pop, so a full FIFO refuses even when
    // it is about to drain one entry.
    assign iwr_ready = !clear && (level_q < LvlW'(wbFifoDepth));
    assign push      = iwr_valid && iwr_ready;
    assign pop       = (grant == GNT_FIFO);

    // ------------------------------------------------------------------
    // SRAM drive: granted source steers the macro in the same cycle
    // ------------------------------------------------------------------
    // Route the granted request onto the SRAM pins; idle pins sit at zero.
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (grant)
            GNT_EXT: begin
                sram_en    = 1'b1;
                sram_wen   = ext_req_wen;
                sram_addr  = ext_req_addr;
                sram_wdata = ext_req_wen ? ext_req_wdata : '0;
            end
            GNT_IRD: begin
                sram_en    = 1'b1;
                sram_addr  = ird_req_addr;
            end
            GNT_FIFO: begin
                sram_en    = 1'b1;
                sram_wen   = 1'b1;
                sram_addr  = fifo_addr_q[rptr_q];
                sram_wdata = fifo_data_q[rptr_q];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state: FIFO pointers/level, starvation counter, read tag
    // ------------------------------------------------------------------
    // Compute all control-register updates; clear overrides everything.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        starve_d  = starve_q;
        rd_pend_d = 1'b0;
        rd_tag_d  = rd_tag_q;

        if (clear) begin
            wptr_d   = '0;
            rptr_d   = '0;
            level_d  = '0;
            starve_d = '0;
        end else begin
            // Pointers are PtrW bits wide, so +1 wraps modulo the depth.
            if (push) wptr_d = wptr_q + PtrW'(1);
            if (pop)  rptr_d = rptr_q + PtrW'(1);

            case ({push, pop})
                2'b10:   level_d = level_q + LvlW'(1);
                2'b01:   level_d = level_q - LvlW'(1);
                default: level_d = level_q;
            endcase

            // Count consecutive denied ext cycles, saturating at the limit.
            if (!ext_req_valid || (grant == GNT_EXT)) begin
                starve_d = '0;
            end else if (starve_q != CntW'(starveLimit)) begin
                starve_d = starve_q + CntW'(1);
            end

            // Remember who owns the read data returning next cycle.
            if (grant == GNT_EXT && !ext_req_wen) begin
                rd_pend_d = 1'b1;
                rd_tag_d  = 1'b1;
            end else if (grant == GNT_IRD) begin
                rd_pend_d = 1'b1;
                rd_tag_d  = 1'b0;
            end
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!nrst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            starve_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            starve_q  <= starve_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    // Writeback FIFO storage, written on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the level and pointers define
        // which entries are meaningful, so stale contents are never observed.
        if (push) begin
            fifo_addr_q[wptr_q] <= iwr_addr;
            fifo_data_q[wptr_q] <= iwr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read return and status
    // ------------------------------------------------------------------
    // A clear in the return cycle suppresses the pending read data.
    assign ext_rd_valid = rd_pend_q &&  rd_tag_q && !clear;
    assign ird_rd_valid = rd_pend_q && !rd_tag_q && !clear;
    assign ext_rd_data  = ext_rd_valid ? sram_rdata : '0;
    assign ird_rd_data  = ird_rd_valid ? sram_rdata : '0;

    assign wb_level = level_q;
    assign busy     = fifo_nonempty || rd_pend_q;

endmodule

// File: tb/tb_actbuf_port_arbiter.sv
// Self-checking bench for actbuf_port_arbiter. Directed stimulus pushes the
// expected SRAM accesses and read returns into queues; a negedge monitor pops
// and compares whenever the DUT drives the SRAM or presents read data.

module tb_actbuf_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          nrst;
    logic          clear;
    logic          ext_req_valid;
    logic          ext_req_wen;
    logic [AW-1:0] ext_req_addr;
    logic [DW-1:0] ext_req_wdata;
    logic          ext_req_ready;
    logic          ext_rd_valid;
    logic [DW-1:0] ext_rd_data;
    logic          ird_req_valid;
    logic [AW-1:0] ird_req_addr;
    logic          ird_req_ready;
    logic          ird_rd_valid;
    logic [DW-1:0] ird_rd_data;
    logic          iwr_valid;
    logic [AW-1:0] iwr_addr;
    logic [DW-1:0] iwr_data;
    logic          iwr_ready;
    logic          sram_en;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic [2:0]    wb_level;
    logic          busy;

    actbuf_port_arbiter #(
        .addrWidth(AW), .dataWidth(DW), .wbFifoDepth(4), .starveLimit(8)
    ) dut (
        .clk(clk), .nrst(nrst), .clear(clear),
        .ext_req_valid(ext_req_valid), .ext_req_wen(ext_req_wen),
        .ext_req_addr(ext_req_addr), .ext_req_wdata(ext_req_wdata),
        .ext_req_ready(ext_req_ready), .ext_rd_valid(ext_rd_valid),
        .ext_rd_data(ext_rd_data),
        .ird_req_valid(ird_req_valid), .ird_req_addr(ird_req_addr),
        .ird_req_ready(ird_req_ready), .ird_rd_valid(ird_rd_valid),
        .ird_rd_data(ird_rd_data),
        .iwr_valid(iwr_valid), .iwr_addr(iwr_addr), .iwr_data(iwr_data),
        .iwr_ready(iwr_ready),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .wb_level(wb_level), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro: one-cycle read latency. Unwritten words hold
    // their own address so read data is predictable.
    logic [DW-1:0] mem [4096];
    initial for (int a = 0; a < 4096; a++) mem[a] = DW'(a);
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen) mem[sram_addr] <= sram_wdata;
            else          sram_rdata     <= mem[sram_addr];
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;
    typedef struct {
        logic          is_ext;
        logic [DW-1:0] data;
    } rd_t;

    acc_t acc_q[$];
    rd_t  rd_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic push_acc(input logic wen, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        acc_t e;
        e.wen = wen; e.addr = a; e.data = d;
        acc_q.push_back(e);
    endtask

    task automatic push_rd(input logic is_ext, input logic [DW-1:0] d);
        rd_t e;
        e.is_ext = is_ext; e.data = d;
        rd_q.push_back(e);
    endtask

    function automatic logic [DW-1:0] wb_data(input int k);
        return {4{32'hE0E0_0000 + 32'(k)}};
    endfunction

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return DW'(a);
    endfunction

    // Monitor: compare every SRAM access and every read return in order.
    acc_t m_acc;
    rd_t  m_rd;
    always @(negedge clk) begin
        if (nrst) begin
            if (sram_en) begin
                check("sram_access_expected", DW'(acc_q.size() != 0), DW'(1));
                if (acc_q.size() != 0) begin
                    m_acc = acc_q.pop_front();
                    check("sram_wen", DW'(sram_wen), DW'(m_acc.wen));
                    check("sram_addr", DW'(sram_addr), DW'(m_acc.addr));
                    if (m_acc.wen) check("sram_wdata", sram_wdata, m_acc.data);
                end
            end
            if (ext_rd_valid || ird_rd_valid) begin
                check("rd_return_expected", DW'(rd_q.size() != 0), DW'(1));
                check("rd_valid_onehot", DW'(ext_rd_valid & ird_rd_valid), DW'(0));
                if (rd_q.size() != 0) begin
                    m_rd = rd_q.pop_front();
                    check("rd_owner_ext", DW'(ext_rd_valid), DW'(m_rd.is_ext));
                    check("rd_data", ext_rd_valid ? ext_rd_data : ird_rd_data,
                          m_rd.data);
                end
            end
            if (!ext_rd_valid) check("ext_rd_data_idle", ext_rd_data, '0);
            if (!ird_rd_valid) check("ird_rd_data_idle", ird_rd_data, '0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        clear         = 1'b0;
        ext_req_valid = 1'b0;
        ext_req_wen   = 1'b0;
        ext_req_addr  = '0;
        ext_req_wdata = '0;
        ird_req_valid = 1'b0;
        ird_req_addr  = '0;
        iwr_valid     = 1'b0;
        iwr_addr      = '0;
        iwr_data      = '0;
    endtask

    initial begin
        drive_idle();
        nrst = 1'b0;

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_sram_en",       DW'(sram_en),       '0);
        check("rst_ext_req_ready", DW'(ext_req_ready), '0);
        check("rst_ird_req_ready", DW'(ird_req_ready), '0);
        check("rst_ext_rd_valid",  DW'(ext_rd_valid),  '0);
        check("rst_ird_rd_valid",  DW'(ird_rd_valid),  '0);
        check("rst_iwr_ready",     DW'(iwr_ready),     DW'(1));
        check("rst_wb_level",      DW'(wb_level),      '0);
        check("rst_busy",          DW'(busy),          '0);
        nrst = 1'b1;
        tick();
        check("idle_sram_en",   DW'(sram_en),   '0);
        check("idle_iwr_ready", DW'(iwr_ready), DW'(1));
        check("idle_busy",      DW'(busy),      '0);

        // Ext write then read of 0x010
        tick();
        ext_req_valid = 1'b1; ext_req_wen = 1'b1;
        ext_req_addr = 12'h010; ext_req_wdata = {16{8'hA5}};
        push_acc(1'b1, 12'h010, {16{8'hA5}});
        #1;
        check("ext_wr_ready", DW'(ext_req_ready), DW'(1));
        check("ext_wr_wen",   DW'(sram_wen),      DW'(1));
        tick();
        ext_req_wen = 1'b0; ext_req_wdata = '0;
        push_acc(1'b0, 12'h010, '0);
        push_rd(1'b1, {16{8'hA5}});
        #1;
        check("ext_rd_grant_en",  DW'(sram_en),  DW'(1));
        check("ext_rd_grant_wen", DW'(sram_wen), '0);
        tick();
        ext_req_valid = 1'b0;
        #1;
        check("ext_rd_valid_n1", DW'(ext_rd_valid), DW'(1));
        check("ext_rd_data_n1",  ext_rd_data,       {16{8'hA5}});
        check("ird_rd_valid_n1", DW'(ird_rd_valid), '0);
        tick();
        check("ext_rd_valid_n2", DW'(ext_rd_valid), '0);

        // Writeback latency: no same-cycle bypass
        tick();
        iwr_valid = 1'b1; iwr_addr = 12'h0A0; iwr_data = wb_data(10);
        #1;
        check("wb_no_bypass",  DW'(sram_en),   '0);
        check("wb_push_ready", DW'(iwr_ready), DW'(1));
        tick();
        iwr_valid = 1'b0;
        push_acc(1'b1, 12'h0A0, wb_data(10));
        #1;
        check("wb_level_one", DW'(wb_level), DW'(1));
        check("wb_write_n1",  DW'(sram_wen), DW'(1));
        tick();
        check("wb_drained_level", DW'(wb_level), '0);
        check("wb_drained_busy",  DW'(busy),     '0);

        // Starvation: ird continuous, ext read held; ext wins on cycle 9
        for (int i = 0; i < 11; i++) begin
            tick();
            ird_req_valid = 1'b1;
            ird_req_addr  = 12'h100 + 12'(i);
            ext_req_valid = (i != 9);
            ext_req_wen   = 1'b0;
            ext_req_addr  = 12'h020;
            if (i == 8) begin
                push_acc(1'b0, 12'h020, '0);
                push_rd(1'b1, init_word(12'h020));
            end else begin
                push_acc(1'b0, 12'h100 + 12'(i), '0);
                push_rd(1'b0, init_word(12'h100 + 12'(i)));
            end
            #1;
            check("starve_ext_ready", DW'(ext_req_ready), DW'(i == 8));
            check("starve_ird_ready", DW'(ird_req_ready), DW'(i != 8));
        end
        tick();
        drive_idle();
        tick();

        // Writeback pressure: nearly-full FIFO pre-empts continuous ird
        for (int i = 0; i < 7; i++) begin
            tick();
            ird_req_valid = (i < 5);
            ird_req_addr  = 12'h200 + 12'(i);
            iwr_valid     = (i < 3);
            iwr_addr      = 12'h300 + 12'(i);
            iwr_data      = wb_data(i);
            case (i)
                3:       push_acc(1'b1, 12'h300, wb_data(0));
                5:       push_acc(1'b1, 12'h301, wb_data(1));
                6:       push_acc(1'b1, 12'h302, wb_data(2));
                default: begin
                    push_acc(1'b0, 12'h200 + 12'(i), '0);
                    push_rd(1'b0, init_word(12'h200 + 12'(i)));
                end
            endcase
            #1;
            if (i < 5) check("wbp_iwr_ready", DW'(iwr_ready), DW'(1));
            if (i == 3) begin
                check("wbp_level_3",   DW'(wb_level),      DW'(3));
                check("wbp_ird_held",  DW'(ird_req_ready), '0);
            end
        end
        tick();
        drive_idle();
        #1;
        check("wbp_level_0", DW'(wb_level), '0);

        // Full FIFO while ext is forced by starvation
        for (int i = 0; i < 16; i++) begin
            tick();
            ird_req_valid = (i < 13);
            ird_req_addr  = 12'h400 + 12'(i);
            ext_req_valid = (i <= 8);
            ext_req_wen   = 1'b0;
            ext_req_addr  = 12'h030;
            iwr_valid     = (i >= 5) && (i <= 10);
            iwr_addr      = 12'h500 + 12'((i > 9) ? 4 : (i - 5));
            iwr_data      = wb_data(16 + ((i > 9) ? 4 : (i - 5)));
            case (i)
                8: begin
                    push_acc(1'b0, 12'h030, '0);
                    push_rd(1'b1, init_word(12'h030));
                end
                9:  push_acc(1'b1, 12'h500, wb_data(16));
                10: push_acc(1'b1, 12'h501, wb_data(17));
                11: push_acc(1'b1, 12'h502, wb_data(18));
                13: push_acc(1'b1, 12'h503, wb_data(19));
                14: push_acc(1'b1, 12'h504, wb_data(20));
                15: ;
                default: begin
                    push_acc(1'b0, 12'h400 + 12'(i), '0);
                    push_rd(1'b0, init_word(12'h400 + 12'(i)));
                end
            endcase
            #1;
            case (i)
                8: begin
                    check("full_ext_forced", DW'(ext_req_ready), DW'(1));
                    check("full_level_3",    DW'(wb_level),      DW'(3));
                end
                9: begin
                    check("full_iwr_ready_0", DW'(iwr_ready), '0);
                    check("full_level_4",     DW'(wb_level),  DW'(4));
                end
                10: begin
                    check("full_fifth_refused", DW'(wb_level),  DW'(3));
                    check("full_iwr_ready_1",   DW'(iwr_ready), DW'(1));
                end
                11: check("full_push_pop_level", DW'(wb_level), DW'(3));
                12: check("full_level_2",        DW'(wb_level), DW'(2));
                15: check("full_level_0",        DW'(wb_level), '0);
                default: ;
            endcase
        end
        tick();
        drive_idle();

        // Clear mid-operation: ird read at N, clear at N+1, two entries queued
        for (int i = 0; i < 5; i++) begin
            tick();
            drive_idle();
            case (i)
                0, 1: begin
                    ird_req_valid = 1'b1;
                    ird_req_addr  = 12'h600 + 12'(i);
                    iwr_valid     = 1'b1;
                    iwr_addr      = 12'h700 + 12'(i);
                    iwr_data      = wb_data(32 + i);
                    push_acc(1'b0, 12'h600 + 12'(i), '0);
                    push_rd(1'b0, init_word(12'h600 + 12'(i)));
                end
                2: begin
                    ird_req_valid = 1'b1;
                    ird_req_addr  = 12'h602;
                    push_acc(1'b0, 12'h602, '0);
                end
                3: begin
                    clear         = 1'b1;
                    ird_req_valid = 1'b1;
                    ird_req_addr  = 12'h603;
                end
                default: ;
            endcase
            #1;
            case (i)
                2: begin
                    check("clr_pre_level", DW'(wb_level), DW'(2));
                    check("clr_pre_busy",  DW'(busy),     DW'(1));
                end
                3: begin
                    check("clr_rd_suppressed", DW'(ird_rd_valid),  '0);
                    check("clr_ird_ready",     DW'(ird_req_ready), '0);
                    check("clr_iwr_ready",     DW'(iwr_ready),     '0);
                    check("clr_no_grant",      DW'(sram_en),       '0);
                end
                4: begin
                    check("clr_level", DW'(wb_level), '0);
                    check("clr_busy",  DW'(busy),     '0);
                end
                default: ;
            endcase
        end
        repeat (4) tick();

        check("sb_acc_drained", DW'(acc_q.size()), '0);
        check("sb_rd_drained",  DW'(rd_q.size()),  '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
